// File: rtl/sub_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub_serial_pkg
// Description : Shared state encoding and default keys for the serial subtractor.
// Revision    : 1.0
// ============================================================================
package sub_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int          DEF_WIDTH = 8;
    // Operand masks shared with the producer; truncated to WIDTH at use.
    localparam logic [31:0] DEF_A_KEY = 32'h0000_0019;
    localparam logic [31:0] DEF_B_KEY = 32'h0000_00EB;

endpackage
`default_nettype wire

// File: rtl/sub_serial.sv
`default_nettype none
// ============================================================================
// Module      : sub_serial
// Description : Bit-serial A-B subtractor, LSB first, with key unmasking on load.
// Revision    : 1.0
// ============================================================================
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] A_KEY = WIDTH'(DEF_A_KEY),
    parameter logic [WIDTH-1:0] B_KEY = WIDTH'(DEF_B_KEY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             borrow,
    output logic             done,
    output logic             busy
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               diff_bit;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        out_d    = out_q;
        borrow_d = borrow_q;
        count_d  = count_q;
        diff_bit = a_q[0] ^ b_q[0] ^ borrow_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    a_d      = a ^ A_KEY;
                    b_d      = b ^ B_KEY;
                    out_d    = '0;
                    borrow_d = 1'b0;
                    count_d  = '0;
                    state_d  = SUB;
                end
            end
            SUB: begin
                borrow_d = (~a_q[0] & b_q[0]) | (~a_q[0] & borrow_q) | (b_q[0] & borrow_q);
                out_d    = {diff_bit, out_q[WIDTH-1:1]};
                a_d      = {1'b0, a_q[WIDTH-1:1]};
                b_d      = {1'b0, b_q[WIDTH-1:1]};
                count_d  = count_q + CNT_W'(1);
                if (count_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            borrow_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            out_q    <= out_d;
            borrow_q <= borrow_d;
            count_q  <= count_d;
        end
    end

    assign out    = out_q;
    assign borrow = borrow_q;
    assign done   = (state_q == DONE);
    assign busy   = (state_q != IDLE);

endmodule
`default_nettype wire
